// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer for an external combinational ALU: fetches operands
// from a small register file, captures the ALU result and flags, then writes them back.
module alu_exec_ctrl #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [7:0]               instr,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [1:0]               alu_sel,
  input  logic [DATA_W-1:0]        alu_result,
  input  logic                     alu_carry,
  input  logic                     alu_overflow,
  input  logic                     alu_negative,
  input  logic                     alu_zero,
  output logic                     done,
  output logic                     flag_c,
  output logic                     flag_v,
  output logic                     flag_n,
  output logic                     flag_z
);

  localparam int AW = $clog2(NREGS);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] regs [NREGS];
  logic [5:0]        instr_q;
  logic [DATA_W-1:0] res_q;
  logic [3:0]        hflags_q;
  logic [1:0]        op_q;
  logic [AW-1:0]     rd_q, rs_q;
  logic              unused_instr_bits;

  assign op_q = instr_q[5:4];
  assign rd_q = instr_q[3:2];
  assign rs_q = instr_q[1:0];
  assign unused_instr_bits = ^instr[1:0];

  assign rd_data = regs[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nx = READ;
      end
      READ:    state_nx = EXEC;
      EXEC:    state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Host writes share the IDLE edge with a handshake, so READ sees the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < unsigned'(NREGS); i++) regs[i] <= '0;
      instr_q  <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      res_q    <= '0;
      hflags_q <= '0;
      done     <= 1'b0;
      flag_c   <= 1'b0;
      flag_v   <= 1'b0;
      flag_n   <= 1'b0;
      flag_z   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en)       regs[wr_addr] <= wr_data;
          if (instr_valid) instr_q       <= instr[7:2];
        end
        READ: begin
          alu_a   <= regs[rd_q];
          alu_b   <= regs[rs_q];
          alu_sel <= op_q;
        end
        EXEC: begin
          res_q    <= alu_result;
          hflags_q <= {alu_carry, alu_overflow, alu_negative, alu_zero};
        end
        WB: begin
          regs[rd_q] <= res_q;
          {flag_c, flag_v, flag_n, flag_z} <= hflags_q;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
